mux_scan_ctrl: RTL and testbench

- **Function:** sequencer that drives the select lines of the team's parameterised n-bit mux and samples the mux's 1-bit output each cycle. It rebuilds the full 2^SELECT_WIDTH-bit mux input word and presents it on a valid/ready output port.
- **Position:** directly upstream of the mux on the select path and directly downstream of it on the data path.
- **Uses:** bring-up and self-check of mux-based datapaths in the project, and as a serial-scan front end for wider capture logic.

---
 rtl/mux_scan_pkg.sv | 10 +
 rtl/mux_scan_ctrl.sv | 93 +++++++++
 tb/tb_mux_scan_ctrl.sv | 363 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg: scan state encoding and word-width helper shared by mux-related blocks
package mux_scan_pkg;

    typedef enum logic [1:0] {IDLE, SCAN, HOLD} scan_state_e;

    function automatic int scan_width(input int select_width);
        return 1 << select_width;
    endfunction

endpackage

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: steps a mux select through every input, samples its output and presents the rebuilt word on a valid/ready port
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int SELECT_WIDTH = 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    output logic [SELECT_WIDTH-1:0]               mux_sel,
    input  logic                                  mux_bit,
    output logic                                  busy,
    output logic [scan_width(SELECT_WIDTH)-1:0]   dout,
    output logic                                  dout_valid,
    input  logic                                  dout_ready
);

    localparam int W = scan_width(SELECT_WIDTH);
    localparam logic [SELECT_WIDTH-1:0] LAST = SELECT_WIDTH'(W - 1);

    scan_state_e             state_q, state_d;
    logic [SELECT_WIDTH-1:0] sel_q, sel_d;
    logic [W-1:0]            cap_q, cap_d;
    logic [W-1:0]            dout_q, dout_d;
    logic                    busy_q, busy_d;
    logic                    valid_q, valid_d;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cap_d   = cap_q;
        dout_d  = dout_q;
        busy_d  = busy_q;
        valid_d = valid_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SCAN;
                    sel_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            SCAN: begin
                cap_d[sel_q] = mux_bit;
                sel_d        = sel_q + 1'b1;
                // cap_d already carries the final bit, so the word is complete here
                if (sel_q == LAST) begin
                    dout_d  = cap_d;
                    state_d = HOLD;
                    valid_d = 1'b1;
                end
            end
            HOLD: begin
                if (dout_ready) begin
                    state_d = start ? SCAN : IDLE;
                    sel_d   = '0;
                    busy_d  = start;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                sel_d   = '0;
                busy_d  = 1'b0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            cap_q   <= '0;
            dout_q  <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cap_q   <= cap_d;
            dout_q  <= dout_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
        end
    end

    assign mux_sel    = sel_q;
    assign busy       = busy_q;
    assign dout       = dout_q;
    assign dout_valid = valid_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb_mux_scan_ctrl: scoreboard bench for mux_scan_ctrl at select widths 1, 2 and 4 with a behavioural mux
module tb_mux_scan_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    logic       start2 = 1'b0, ready2 = 1'b0, bit2, busy2, valid2;
    logic [3:0] mux_in2 = '0, dout2;
    logic [1:0] sel2;
    logic [3:0] q2[$];
    logic [3:0] exp2;

    logic       start1 = 1'b0, ready1 = 1'b0, bit1, busy1, valid1;
    logic [1:0] mux_in1 = '0, dout1;
    logic [0:0] sel1;
    logic [1:0] q1[$];
    logic [1:0] exp1;

    logic        start4 = 1'b0, ready4 = 1'b0, bit4, busy4, valid4;
    logic [15:0] mux_in4 = '0, dout4;
    logic [3:0]  sel4;
    logic [15:0] q4[$];
    logic [15:0] exp4;

    assign bit2 = mux_in2[sel2];
    assign bit1 = mux_in1[sel1];
    assign bit4 = mux_in4[sel4];

    mux_scan_ctrl #(.SELECT_WIDTH(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .mux_sel(sel2), .mux_bit(bit2),
        .busy(busy2), .dout(dout2), .dout_valid(valid2), .dout_ready(ready2)
    );

    mux_scan_ctrl #(.SELECT_WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .mux_sel(sel1), .mux_bit(bit1),
        .busy(busy1), .dout(dout1), .dout_valid(valid1), .dout_ready(ready1)
    );

    mux_scan_ctrl #(.SELECT_WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .mux_sel(sel4), .mux_bit(bit4),
        .busy(busy4), .dout(dout4), .dout_valid(valid4), .dout_ready(ready4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick();
        n_checks++;
        if ({sel2, busy2, dout2, valid2} !== 8'b0) begin
            n_fail++;
            $display("FAIL reset_w2: sel=%0d busy=%b dout=%b valid=%b, all required 0", sel2, busy2, dout2, valid2);
        end
        n_checks++;
        if ({sel1, busy1, dout1, valid1} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_w1: sel=%0d busy=%b dout=%b valid=%b, all required 0", sel1, busy1, dout1, valid1);
        end
        n_checks++;
        if ({sel4, busy4, dout4, valid4} !== 22'b0) begin
            n_fail++;
            $display("FAIL reset_w4: sel=%0d busy=%b dout=%h valid=%b, all required 0", sel4, busy4, dout4, valid4);
        end
        rst = 1'b0;
        tick();
        n_checks++;
        if (busy2 !== 1'b0 || valid2 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: busy=%b valid=%b, required 0/0", busy2, valid2);
        end
    endtask

    task automatic test_basic_scan();
        mux_in2 = 4'b1010;
        start2 = 1'b1;
        q2.push_back(mux_in2);
        tick();
        start2 = 1'b0;
        n_checks++;
        if (busy2 !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_busy: got %b required 1", busy2);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (sel2 !== 2'(i) || valid2 !== 1'b0) begin
                n_fail++;
                $display("FAIL basic_sel: cycle %0d sel=%0d valid=%b, required sel=%0d valid=0", i, sel2, valid2, i);
            end
            tick();
        end
        n_checks++;
        if (valid2 !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_valid: got %b required 1 four cycles after start", valid2);
        end
        ready2 = 1'b1;
        n_checks++;
        if (q2.size() == 0) begin
            n_fail++;
            $display("FAIL basic_pop: scoreboard empty, dout=%b", dout2);
        end else begin
            exp2 = q2.pop_front();
            if (dout2 !== exp2) begin
                n_fail++;
                $display("FAIL basic_dout: got %b required %b", dout2, exp2);
            end
        end
        tick();
        ready2 = 1'b0;
        n_checks++;
        if (busy2 !== 1'b0 || valid2 !== 1'b0 || dout2 !== 4'b1010) begin
            n_fail++;
            $display("FAIL basic_release: busy=%b valid=%b dout=%b, required 0/0/1010", busy2, valid2, dout2);
        end
    endtask

    task automatic test_back_to_back();
        mux_in2 = 4'b0110;
        start2 = 1'b1;
        q2.push_back(mux_in2);
        tick();
        start2 = 1'b0;
        repeat (4) tick();
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (valid2 !== 1'b1 || dout2 !== 4'b0110) begin
                n_fail++;
                $display("FAIL hold_stable: cycle %0d valid=%b dout=%b, required 1/0110", i, valid2, dout2);
            end
            tick();
        end
        mux_in2 = 4'b1001;
        ready2 = 1'b1;
        start2 = 1'b1;
        n_checks++;
        if (q2.size() == 0) begin
            n_fail++;
            $display("FAIL b2b_pop1: scoreboard empty, dout=%b", dout2);
        end else begin
            exp2 = q2.pop_front();
            if (dout2 !== exp2 || valid2 !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_dout1: got %b valid=%b required %b valid=1", dout2, valid2, exp2);
            end
        end
        q2.push_back(mux_in2);
        tick();
        ready2 = 1'b0;
        start2 = 1'b0;
        n_checks++;
        if (busy2 !== 1'b1 || sel2 !== 2'd0 || valid2 !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_restart: busy=%b sel=%0d valid=%b, required 1/0/0", busy2, sel2, valid2);
        end
        repeat (3) tick();
        n_checks++;
        if (valid2 !== 1'b0 || busy2 !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_early: valid=%b busy=%b before scan end, required 0/1", valid2, busy2);
        end
        tick();
        ready2 = 1'b1;
        n_checks++;
        if (q2.size() == 0) begin
            n_fail++;
            $display("FAIL b2b_pop2: scoreboard empty, dout=%b", dout2);
        end else begin
            exp2 = q2.pop_front();
            if (dout2 !== exp2 || valid2 !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_dout2: got %b valid=%b required %b valid=1", dout2, valid2, exp2);
            end
        end
        tick();
        ready2 = 1'b0;
        n_checks++;
        if (busy2 !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle: busy=%b required 0", busy2);
        end
    endtask

    task automatic test_start_ignored();
        mux_in2 = 4'b0011;
        start2 = 1'b1;
        q2.push_back(mux_in2);
        tick();
        start2 = 1'b0;
        tick();
        tick();
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        n_checks++;
        if (sel2 !== 2'd3) begin
            n_fail++;
            $display("FAIL ign_scan: sel=%0d after start during scan, required 3", sel2);
        end
        tick();
        start2 = 1'b1;
        repeat (2) tick();
        start2 = 1'b0;
        n_checks++;
        if (valid2 !== 1'b1 || busy2 !== 1'b1 || sel2 !== 2'd0 || dout2 !== 4'b0011) begin
            n_fail++;
            $display("FAIL ign_hold: valid=%b busy=%b sel=%0d dout=%b, required 1/1/0/0011", valid2, busy2, sel2, dout2);
        end
        ready2 = 1'b1;
        n_checks++;
        if (q2.size() == 0) begin
            n_fail++;
            $display("FAIL ign_pop: scoreboard empty, dout=%b", dout2);
        end else begin
            exp2 = q2.pop_front();
            if (dout2 !== exp2) begin
                n_fail++;
                $display("FAIL ign_dout: got %b required %b", dout2, exp2);
            end
        end
        tick();
        ready2 = 1'b0;
        repeat (6) tick();
        n_checks++;
        if (valid2 !== 1'b0 || busy2 !== 1'b0) begin
            n_fail++;
            $display("FAIL ign_single: valid=%b busy=%b, required 0/0 (one word only)", valid2, busy2);
        end
    endtask

    task automatic test_reset_mid_scan();
        mux_in2 = 4'b0101;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        tick();
        tick();
        n_checks++;
        if (sel2 !== 2'd2) begin
            n_fail++;
            $display("FAIL rmid_sel: sel=%0d before reset, required 2", sel2);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (sel2 !== 2'd0 || busy2 !== 1'b0 || dout2 !== 4'b0 || valid2 !== 1'b0) begin
            n_fail++;
            $display("FAIL rmid_async: sel=%0d busy=%b dout=%b valid=%b, required all 0", sel2, busy2, dout2, valid2);
        end
        tick();
        rst = 1'b0;
        tick();
        mux_in2 = 4'b1111;
        start2 = 1'b1;
        q2.push_back(mux_in2);
        tick();
        start2 = 1'b0;
        repeat (4) tick();
        ready2 = 1'b1;
        n_checks++;
        if (q2.size() == 0) begin
            n_fail++;
            $display("FAIL rmid_pop: scoreboard empty, dout=%b", dout2);
        end else begin
            exp2 = q2.pop_front();
            if (dout2 !== exp2 || valid2 !== 1'b1) begin
                n_fail++;
                $display("FAIL rmid_dout: got %b valid=%b required %b valid=1", dout2, valid2, exp2);
            end
        end
        tick();
        ready2 = 1'b0;
    endtask

    task automatic test_width1();
        mux_in1 = 2'b10;
        start1 = 1'b1;
        q1.push_back(mux_in1);
        tick();
        start1 = 1'b0;
        tick();
        n_checks++;
        if (valid1 !== 1'b0 || sel1 !== 1'b1) begin
            n_fail++;
            $display("FAIL w1_mid: valid=%b sel=%0d, required 0/1", valid1, sel1);
        end
        tick();
        ready1 = 1'b1;
        n_checks++;
        if (q1.size() == 0) begin
            n_fail++;
            $display("FAIL w1_pop: scoreboard empty, dout=%b", dout1);
        end else begin
            exp1 = q1.pop_front();
            if (dout1 !== exp1 || valid1 !== 1'b1 || sel1 !== 1'b0) begin
                n_fail++;
                $display("FAIL w1_dout: got %b valid=%b sel=%0d required %b valid=1 sel=0", dout1, valid1, sel1, exp1);
            end
        end
        tick();
        ready1 = 1'b0;
    endtask

    task automatic test_width4();
        mux_in4 = 16'hA5C3;
        start4 = 1'b1;
        q4.push_back(mux_in4);
        tick();
        start4 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (sel4 !== 4'(i) || valid4 !== 1'b0) begin
                n_fail++;
                $display("FAIL w4_sel: cycle %0d sel=%0d valid=%b, required sel=%0d valid=0", i, sel4, valid4, i);
            end
            tick();
        end
        ready4 = 1'b1;
        n_checks++;
        if (q4.size() == 0) begin
            n_fail++;
            $display("FAIL w4_pop: scoreboard empty, dout=%h", dout4);
        end else begin
            exp4 = q4.pop_front();
            if (dout4 !== exp4 || valid4 !== 1'b1 || sel4 !== 4'd0) begin
                n_fail++;
                $display("FAIL w4_dout: got %h valid=%b sel=%0d required %h valid=1 sel=0", dout4, valid4, sel4, exp4);
            end
        end
        tick();
        ready4 = 1'b0;
        n_checks++;
        if (q1.size() + q2.size() + q4.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d expected words never produced, required 0", q1.size() + q2.size() + q4.size());
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_scan();
        test_back_to_back();
        test_start_ignored();
        test_reset_mid_scan();
        test_width1();
        test_width4();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
